// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, forwarding, flush and memory-wait control
// Stall/bubble/flush act combinationally this cycle; forwarding selects are latched on each advance.
module pipeline_hazard_ctrl #(
  parameter int WDOG_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_num_Rm,
  input  logic [2:0]  id_num_Rn,
  input  logic        id_use_Rm,
  input  logic        id_use_Rn,
  input  logic [2:0]  ex_num_Rd,
  input  logic        ex_writes,
  input  logic        ex_loads,
  input  logic [2:0]  mem_num_Rd,
  input  logic        mem_writes,
  input  logic        mem_busy,
  input  logic        branch_taken,
  output logic        stall_front,
  output logic        stall_back,
  output logic        bubble,
  output logic        flush,
  output logic [1:0]  fwd_Rm_sel,
  output logic [1:0]  fwd_Rn_sel,
  output logic [15:0] stall_cycles,
  output logic        mem_timeout
);

  localparam int WDOG_W = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  state_t            state;
  state_t            next_state;
  logic              load_use;
  logic [WDOG_W-1:0] wdog;

  assign load_use = id_valid & ex_loads & ex_writes &
                    ((id_use_Rm & (id_num_Rm == ex_num_Rd)) |
                     (id_use_Rn & (id_num_Rn == ex_num_Rd)));

  // The EX-stage producer is younger than the MEM-stage one, so it wins.
  function automatic logic [1:0] sel_for(input logic used, input logic [2:0] num,
                                         input logic exw, input logic [2:0] exrd,
                                         input logic memw, input logic [2:0] memrd);
    if (!used)                    return 2'b00;
    else if (exw && num == exrd)  return 2'b01;
    else if (memw && num == memrd) return 2'b10;
    else                          return 2'b00;
  endfunction

  always_comb begin
    stall_front = 1'b0;
    stall_back  = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    next_state  = state;
    case (state)
      RUN: begin
        if (mem_busy) begin
          stall_front = 1'b1;
          stall_back  = 1'b1;
          next_state  = MEM_WAIT;
        end else if (branch_taken) begin
          flush      = 1'b1;
          bubble     = 1'b1;
          next_state = FLUSH;
        end else if (load_use) begin
          stall_front = 1'b1;
          bubble      = 1'b1;
        end
      end
      FLUSH: begin
        // A stall here drops the second flush: IF/ID was already killed.
        if (mem_busy) begin
          stall_front = 1'b1;
          stall_back  = 1'b1;
          next_state  = MEM_WAIT;
        end else begin
          flush      = 1'b1;
          next_state = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          stall_front = 1'b1;
          stall_back  = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
    if (rst) begin
      stall_front = 1'b0;
      stall_back  = 1'b0;
      bubble      = 1'b0;
      flush       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      fwd_Rm_sel   <= 2'b00;
      fwd_Rn_sel   <= 2'b00;
      stall_cycles <= 16'd0;
      wdog         <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state <= next_state;
      if (!stall_front && !stall_back) begin
        if (bubble) begin
          fwd_Rm_sel <= 2'b00;
          fwd_Rn_sel <= 2'b00;
        end else begin
          fwd_Rm_sel <= sel_for(id_use_Rm, id_num_Rm, ex_writes, ex_num_Rd, mem_writes, mem_num_Rd);
          fwd_Rn_sel <= sel_for(id_use_Rn, id_num_Rn, ex_writes, ex_num_Rd, mem_writes, mem_num_Rd);
        end
      end
      if (stall_front && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (state == MEM_WAIT) begin
        if (wdog < WDOG_W'(WDOG_LIMIT))
          wdog <= wdog + 1'b1;
        if (wdog >= WDOG_W'(WDOG_LIMIT - 1))
          mem_timeout <= 1'b1;
      end else begin
        wdog <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
// Directed scenarios plus randomized traffic against a behavioural reference model.
module tb_pipeline_hazard_ctrl;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_use_Rm, id_use_Rn, ex_writes, ex_loads, mem_writes, mem_busy, branch_taken;
  logic [2:0] id_num_Rm, id_num_Rn, ex_num_Rd, mem_num_Rd;
  logic stall_front, stall_back, bubble, flush, mem_timeout;
  logic [1:0] fwd_Rm_sel, fwd_Rn_sel;
  logic [15:0] stall_cycles;

  int cmp = 0;
  int errs = 0;

  // reference model: pending-flush / waiting flags instead of a state register
  bit m_wait, m_flush, m_to;
  logic [1:0] m_rm, m_rn;
  int m_stalls, m_cnt;
  bit e_sf, e_sb, e_bub, e_fl;

  pipeline_hazard_ctrl #(.WDOG_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_num_Rm(id_num_Rm), .id_num_Rn(id_num_Rn),
    .id_use_Rm(id_use_Rm), .id_use_Rn(id_use_Rn),
    .ex_num_Rd(ex_num_Rd), .ex_writes(ex_writes), .ex_loads(ex_loads),
    .mem_num_Rd(mem_num_Rd), .mem_writes(mem_writes), .mem_busy(mem_busy),
    .branch_taken(branch_taken), .stall_front(stall_front), .stall_back(stall_back),
    .bubble(bubble), .flush(flush), .fwd_Rm_sel(fwd_Rm_sel), .fwd_Rn_sel(fwd_Rn_sel),
    .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_sel(input bit used, input logic [2:0] n);
    if (!used) return 2'd0;
    if (ex_writes && n == ex_num_Rd) return 2'd1;
    if (mem_writes && n == mem_num_Rd) return 2'd2;
    return 2'd0;
  endfunction

  function automatic void model_comb();
    bit lu;
    lu = id_valid && ex_loads && ex_writes &&
         ((id_use_Rm && id_num_Rm == ex_num_Rd) || (id_use_Rn && id_num_Rn == ex_num_Rd));
    e_sf = 0; e_sb = 0; e_bub = 0; e_fl = 0;
    if (mem_busy) begin
      e_sf = 1; e_sb = 1;
    end else if (m_wait) begin
      // memory just returned: one clean advance
    end else if (m_flush) begin
      e_fl = 1;
    end else if (branch_taken) begin
      e_fl = 1; e_bub = 1;
    end else if (lu) begin
      e_sf = 1; e_bub = 1;
    end
  endfunction

  function automatic void model_step();
    bit nf;
    model_comb();
    if (e_sf) m_stalls = (m_stalls >= 65535) ? 65535 : m_stalls + 1;
    if (!e_sf && !e_sb) begin
      m_rm = e_bub ? 2'd0 : ref_sel(id_use_Rm, id_num_Rm);
      m_rn = e_bub ? 2'd0 : ref_sel(id_use_Rn, id_num_Rn);
    end
    if (m_wait) begin
      m_cnt++;
      if (m_cnt >= LIM) m_to = 1;
    end else begin
      m_cnt = 0;
    end
    nf = !mem_busy && !m_wait && !m_flush && branch_taken;
    m_wait = mem_busy;
    m_flush = nf;
  endfunction

  function automatic void model_reset();
    m_wait = 0; m_flush = 0; m_to = 0; m_rm = 0; m_rn = 0; m_stalls = 0; m_cnt = 0;
  endfunction

  task automatic idle();
    id_valid = 0; id_use_Rm = 0; id_use_Rn = 0; id_num_Rm = 0; id_num_Rn = 0;
    ex_num_Rd = 0; ex_writes = 0; ex_loads = 0; mem_num_Rd = 0; mem_writes = 0;
    mem_busy = 0; branch_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle();
    id_valid = 1; id_use_Rm = 1; id_num_Rm = 5; ex_num_Rd = 5; ex_writes = 1; ex_loads = 1;
    branch_taken = 1;
    #2;
    cmp++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b0000) begin
      errs++; $display("FAIL reset_ctl: got %b want 0000", {stall_front, stall_back, bubble, flush});
    end
    cmp++;
    if ({fwd_Rm_sel, fwd_Rn_sel, stall_cycles, mem_timeout} !== 21'd0) begin
      errs++; $display("FAIL reset_regs: rm=%b rn=%b cyc=%0d to=%b want all 0",
                       fwd_Rm_sel, fwd_Rn_sel, stall_cycles, mem_timeout);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    id_valid = 1; id_use_Rm = 1; id_num_Rm = 3; ex_num_Rd = 3; ex_writes = 1; ex_loads = 1;
    #1;
    cmp++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b1010) begin
      errs++; $display("FAIL load_use_ctl: sf/sb/bub/fl=%b want 1010", {stall_front, stall_back, bubble, flush});
    end
    tick();
    cmp++;
    if (stall_cycles !== 16'd1 || fwd_Rm_sel !== 2'b00) begin
      errs++; $display("FAIL load_use_hold: cyc=%0d rm=%b want 1 00", stall_cycles, fwd_Rm_sel);
    end
    idle();
    id_valid = 1; id_use_Rm = 1; id_num_Rm = 3; mem_num_Rd = 3; mem_writes = 1;
    #1;
    cmp++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b0000) begin
      errs++; $display("FAIL load_use_clear: got %b want 0000", {stall_front, stall_back, bubble, flush});
    end
    tick();
    cmp++;
    if (fwd_Rm_sel !== 2'b10) begin
      errs++; $display("FAIL load_use_fwd: rm=%b want 10", fwd_Rm_sel);
    end
  endtask

  task automatic test_fwd_priority();
    idle();
    id_valid = 1; id_use_Rn = 1; id_num_Rn = 2; id_num_Rm = 2;
    ex_num_Rd = 2; ex_writes = 1; mem_num_Rd = 2; mem_writes = 1;
    #1;
    tick();
    cmp++;
    if (fwd_Rn_sel !== 2'b01 || fwd_Rm_sel !== 2'b00) begin
      errs++; $display("FAIL fwd_ex_wins: rn=%b rm=%b want 01 00", fwd_Rn_sel, fwd_Rm_sel);
    end
    id_use_Rn = 0;
    #1;
    tick();
    cmp++;
    if (fwd_Rn_sel !== 2'b00) begin
      errs++; $display("FAIL fwd_unused: rn=%b want 00", fwd_Rn_sel);
    end
  endtask

  task automatic test_branch();
    logic [3:0] want [3];
    want[0] = 4'b0011; want[1] = 4'b0001; want[2] = 4'b0000;
    idle();
    id_valid = 1; id_use_Rm = 1; id_num_Rm = 1; ex_num_Rd = 1; ex_writes = 1;
    for (int k = 0; k < 3; k++) begin
      branch_taken = (k < 2);
      #1;
      cmp++;
      if ({stall_front, stall_back, bubble, flush} !== want[k]) begin
        errs++; $display("FAIL branch_n%0d: sf/sb/bub/fl=%b want %b", k,
                         {stall_front, stall_back, bubble, flush}, want[k]);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    idle();
    id_valid = 1; id_use_Rm = 1; id_num_Rm = 6; ex_num_Rd = 6; ex_writes = 1;
    #1;
    tick();
    ex_loads = 1; mem_busy = 1; branch_taken = 1;
    #1;
    cmp++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b1100) begin
      errs++; $display("FAIL simul_ctl: got %b want 1100", {stall_front, stall_back, bubble, flush});
    end
    tick();
    cmp++;
    if (fwd_Rm_sel !== 2'b01 || fwd_Rm_sel !== m_rm) begin
      errs++; $display("FAIL simul_hold: rm=%b want 01", fwd_Rm_sel);
    end
    idle();
    branch_taken = 1;
    #1;
    cmp++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b0000) begin
      errs++; $display("FAIL wait_exit: got %b want 0000", {stall_front, stall_back, bubble, flush});
    end
    branch_taken = 0;
    tick();
  endtask

  task automatic test_watchdog();
    idle();
    mem_busy = 1;
    #1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      cmp++;
      if (mem_timeout !== (k >= LIM) || mem_timeout !== m_to) begin
        errs++; $display("FAIL wdog_k%0d: to=%b want %b", k, mem_timeout, (k >= LIM));
      end
    end
    mem_busy = 0;
    #1;
    tick();
    tick();
    cmp++;
    if (mem_timeout !== 1'b1) begin
      errs++; $display("FAIL wdog_sticky: to=%b want 1", mem_timeout);
    end
    rst = 1;
    #1;
    cmp++;
    if (mem_timeout !== 1'b0) begin
      errs++; $display("FAIL wdog_rst: to=%b want 0", mem_timeout);
    end
    rst = 0;
    model_reset();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_use_Rm = 1'($urandom); id_use_Rn = 1'($urandom);
      id_num_Rm = 3'($urandom_range(0, 3)); id_num_Rn = 3'($urandom_range(0, 3));
      ex_num_Rd = 3'($urandom_range(0, 3)); ex_writes = 1'($urandom);
      ex_loads = 1'($urandom);
      mem_num_Rd = 3'($urandom_range(0, 3)); mem_writes = 1'($urandom);
      mem_busy = 1'($urandom_range(0, 5) == 0);
      branch_taken = 1'($urandom_range(0, 7) == 0);
      #1;
      model_comb();
      cmp++;
      if ({stall_front, stall_back, bubble, flush} !== {e_sf, e_sb, e_bub, e_fl}) begin
        errs++; $display("FAIL rand_ctl@%0d: sf/sb/bub/fl=%b want %b", i,
                         {stall_front, stall_back, bubble, flush}, {e_sf, e_sb, e_bub, e_fl});
      end
      tick();
      cmp++;
      if ({fwd_Rm_sel, fwd_Rn_sel} !== {m_rm, m_rn}) begin
        errs++; $display("FAIL rand_fwd@%0d: rm/rn=%b/%b want %b/%b", i, fwd_Rm_sel, fwd_Rn_sel, m_rm, m_rn);
      end
      cmp++;
      if (stall_cycles !== 16'(m_stalls) || mem_timeout !== m_to) begin
        errs++; $display("FAIL rand_cnt@%0d: cyc=%0d to=%b want %0d %b", i,
                         stall_cycles, mem_timeout, m_stalls, m_to);
      end
    end
  endtask

  task automatic test_async_reset();
    idle();
    branch_taken = 1;
    #1;
    tick();
    branch_taken = 0;
    #1;
    cmp++;
    if (flush !== 1'b1 || stall_cycles === 16'd0) begin
      errs++; $display("FAIL arst_pre: fl=%b cyc=%0d want 1 nonzero", flush, stall_cycles);
    end
    rst = 1;
    #1;
    cmp++;
    if ({stall_front, stall_back, bubble, flush} !== 4'b0000 || stall_cycles !== 16'd0 ||
        {fwd_Rm_sel, fwd_Rn_sel} !== 4'b0000) begin
      errs++; $display("FAIL arst_post: ctl=%b cyc=%0d rm/rn=%b/%b want 0000 0 00/00",
                       {stall_front, stall_back, bubble, flush}, stall_cycles, fwd_Rm_sel, fwd_Rn_sel);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_branch();
    test_simultaneous();
    test_watchdog();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
